// File: rtl/tug_war_ctrl.sv
// Tug-of-war game controller: arbitrates press pulses, moves the marker,
// scores round wins, holds the win display and ends the match.
module tug_war_ctrl #(
  parameter int NPOS        = 9,
  parameter int HOLD_CYCLES = 50000000,
  parameter int MAX_SCORE   = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p1_press,
  input  logic            p2_press,
  output logic [NPOS-1:0] led,
  output logic            win1,
  output logic            win2,
  output logic [2:0]      score1,
  output logic [2:0]      score2,
  output logic            match_over
);

  localparam int PW = $clog2(NPOS);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PW-1:0]   CENTER = PW'((NPOS - 1) / 2);
  localparam logic [PW-1:0]   TOP    = PW'(NPOS - 1);
  localparam logic [CW-1:0]   CLAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]      SMAX   = 3'(MAX_SCORE);
  localparam logic [NPOS-1:0] LED_C  = NPOS'(1) << CENTER;

  typedef enum logic [1:0] {
    PLAY,
    WIN1,
    WIN2,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [CW-1:0] cnt;
  logic          up;
  logic          dn;

  // Simultaneous presses cancel out.
  assign up = p1_press & ~p2_press;
  assign dn = p2_press & ~p1_press;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAY;
      pos        <= CENTER;
      cnt        <= '0;
      led        <= LED_C;
      win1       <= 1'b0;
      win2       <= 1'b0;
      score1     <= 3'd0;
      score2     <= 3'd0;
      match_over <= 1'b0;
    end else begin
      unique case (state)
        PLAY: begin
          if (up) begin
            if (pos == TOP) begin
              led    <= '0;
              win1   <= 1'b1;
              score1 <= score1 + 3'd1;
              cnt    <= '0;
              if (score1 + 3'd1 == SMAX) begin
                state      <= DONE;
                match_over <= 1'b1;
              end else begin
                state <= WIN1;
              end
            end else begin
              pos <= pos + PW'(1);
              led <= led << 1;
            end
          end else if (dn) begin
            if (pos == '0) begin
              led    <= '0;
              win2   <= 1'b1;
              score2 <= score2 + 3'd1;
              cnt    <= '0;
              if (score2 + 3'd1 == SMAX) begin
                state      <= DONE;
                match_over <= 1'b1;
              end else begin
                state <= WIN2;
              end
            end else begin
              pos <= pos - PW'(1);
              led <= led >> 1;
            end
          end
        end
        WIN1, WIN2: begin
          if (cnt == CLAST) begin
            state <= PLAY;
            pos   <= CENTER;
            led   <= LED_C;
            win1  <= 1'b0;
            win2  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_war_ctrl.sv
// Bench for tug_war_ctrl: game-level model checked every cycle plus
// hand-computed directed expectations.
module tb_tug_war_ctrl;

  localparam int NPOS = 9;
  localparam int HOLD = 4;
  localparam int MAXS = 2;
  localparam int CTR  = (NPOS - 1) / 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            p1_press = 1'b0;
  logic            p2_press = 1'b0;
  logic [NPOS-1:0] led;
  logic            win1;
  logic            win2;
  logic [2:0]      score1;
  logic [2:0]      score2;
  logic            match_over;

  int npass = 0;
  int ntot  = 0;

  // Game-level model
  int m_pos;
  int m_hold;
  int m_winner;
  int m_s1;
  int m_s2;
  bit m_over;
  bit m_valid = 1'b0;

  tug_war_ctrl #(
    .NPOS(NPOS),
    .HOLD_CYCLES(HOLD),
    .MAX_SCORE(MAXS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .p1_press(p1_press),
    .p2_press(p2_press),
    .led(led),
    .win1(win1),
    .win2(win2),
    .score1(score1),
    .score2(score2),
    .match_over(match_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_pos    = CTR;
      m_hold   = 0;
      m_winner = 0;
      m_s1     = 0;
      m_s2     = 0;
      m_over   = 1'b0;
      m_valid  = 1'b1;
    end else if (m_over) begin
      m_over = 1'b1;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        m_winner = 0;
        m_pos    = CTR;
      end
    end else if (p1_press && !p2_press) begin
      if (m_pos == NPOS - 1) begin
        m_s1++;
        m_winner = 1;
        if (m_s1 == MAXS) m_over = 1'b1;
        else m_hold = HOLD;
      end else m_pos++;
    end else if (p2_press && !p1_press) begin
      if (m_pos == 0) begin
        m_s2++;
        m_winner = 2;
        if (m_s2 == MAXS) m_over = 1'b1;
        else m_hold = HOLD;
      end else m_pos--;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_led", 32'(led),
          (m_over || m_hold > 0) ? 32'd0 : (32'd1 << m_pos));
      chk("m_win1", 32'(win1), 32'(m_winner == 1));
      chk("m_win2", 32'(win2), 32'(m_winner == 2));
      chk("m_score1", 32'(score1), 32'(m_s1));
      chk("m_score2", 32'(score2), 32'(m_s2));
      chk("m_over", 32'(match_over), 32'(m_over));
    end
  end

  task automatic cyc(input logic a, input logic b);
    p1_press = a;
    p2_press = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    cyc(0, 0);
    cyc(0, 0);
    reset = 1'b0;
    repeat (3) cyc(0, 0);
    chk("rst_led", 32'(led), 32'h010);
    chk("rst_scores", 32'({score1, score2}), 32'd0);
    chk("rst_flags", 32'({win1, win2, match_over}), 32'd0);

    repeat (4) begin
      cyc(1, 0);
      cyc(0, 0);
    end
    chk("p1_to_end", 32'(led), 32'h100);
    cyc(1, 0);
    chk("win1_led", 32'(led), 32'd0);
    chk("win1_flag", 32'(win1), 32'd1);
    chk("win1_score", 32'(score1), 32'd1);
    cyc(1, 0);
    cyc(0, 1);
    cyc(1, 1);
    chk("hold_led", 32'(led), 32'd0);
    chk("hold_win1", 32'(win1), 32'd1);
    chk("hold_scores", 32'({score1, score2}), 32'h08);
    cyc(0, 0);
    chk("resume_led", 32'(led), 32'h010);
    chk("resume_win1", 32'(win1), 32'd0);

    repeat (3) cyc(1, 1);
    chk("cancel_led", 32'(led), 32'h010);
    repeat (4) begin
      cyc(0, 1);
      cyc(0, 0);
    end
    chk("p2_to_end", 32'(led), 32'h001);
    cyc(0, 1);
    chk("win2_flag", 32'(win2), 32'd1);
    chk("win2_score", 32'(score2), 32'd1);
    repeat (4) cyc(0, 0);
    chk("resume2_led", 32'(led), 32'h010);
    chk("resume2_win2", 32'(win2), 32'd0);

    repeat (5) begin
      cyc(1, 0);
      cyc(0, 0);
    end
    chk("done_over", 32'(match_over), 32'd1);
    chk("done_win1", 32'(win1), 32'd1);
    chk("done_score1", 32'(score1), 32'd2);
    chk("done_led", 32'(led), 32'd0);
    for (int i = 0; i < 12; i++) begin
      logic [1:0] v;
      v = 2'(i);
      cyc(v[0], v[1]);
    end
    chk("done_hold", 32'({match_over, win1, win2, score1, score2}),
        32'b1_1_0_010_001);
    chk("done_led2", 32'(led), 32'd0);
    reset = 1'b1;
    cyc(0, 0);
    reset = 1'b0;
    chk("rst2_led", 32'(led), 32'h010);
    chk("rst2_all", 32'({match_over, win1, win2, score1, score2}), 32'd0);

    repeat (4) cyc(1, 0);
    chk("b2b_led", 32'(led), 32'h100);
    reset = 1'b1;
    cyc(1, 0);
    reset = 1'b0;
    chk("rstpri_led", 32'(led), 32'h010);
    chk("rstpri_win", 32'({win1, score1}), 32'd0);
    repeat (3) cyc(0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/tug_war_ctrl.md
# tug_war_ctrl

Game controller for the two-player tug-of-war datapath. Consumes the one-cycle press pulses produced by the per-player key conditioners, arbitrates them, and moves a single lit marker across an LED bar. It detects and scores round wins, holds the win display for a fixed interval, restarts the round, and ends the match when a player reaches the score limit. It sits between the key conditioners and the LEDR/HEX display drivers.

## Interface
- NPOS, 9, number of marker positions/LEDs; odd, ≥3
- HOLD_CYCLES, 50000000, cycles the win display is held before the next round; ≥1
- MAX_SCORE, 7, rounds needed to win the match; 1..7
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  reset, synchronous, active-high
- p1_press  in  1  player-1 press pulse, high at most one cycle per press
- p2_press  in  1  player-2 press pulse, high at most one cycle per press
- led  out  NPOS  one-hot marker; bit NPOS-1 is player-1's end, bit 0 is player-2's end
- win1  out  1  high while player 1's round win is displayed
- win2  out  1  high while player 2's round win is displayed
- score1  out  3  player-1 rounds won
- score2  out  3  player-2 rounds won
- match_over  out  1  high once either score reaches MAX_SCORE

## Operation
- Internal state: pos (index 0..NPOS-1), hold counter, FSM state, scores.
- CENTER = (NPOS-1)/2.
- States: PLAY, WIN1, WIN2, DONE.
- PLAY, per cycle:
  - p1_press only: if pos == NPOS-1, go to WIN1; else pos+1.
  - p2_press only: if pos == 0, go to WIN2; else pos-1.
  - Both or neither high: no change. Simultaneous presses cancel.
  - led = one-hot of pos.
- Entry to WIN1/WIN2: the winner's score increments by exactly 1, and the hold counter loads 0. If the new score == MAX_SCORE, go to DONE instead of WIN.
- WIN1/WIN2:
  - led = all zeros. The matching win output is high.
  - Presses are ignored.
  - The counter increments each cycle. When it reaches HOLD_CYCLES-1, go to PLAY with pos = CENTER.
- DONE:
  - led = all zeros. match_over = 1.
  - win1 or win2 stays high for the match winner.
  - Scores freeze and presses are ignored. Exit only on reset.
- Scores never exceed MAX_SCORE. The counter width is sized for HOLD_CYCLES.
- Reset values: state PLAY, pos CENTER, led = one-hot CENTER, win1 = win2 = 0, score1 = score2 = 0, match_over = 0, counter 0.
- Reset has priority over any press in the same cycle. Reset asserted mid-hold or in DONE returns to the reset values on the next edge.

## Timing
- All outputs are registered. A press sampled at edge k is reflected in led/win/score after edge k (visible in cycle k+1).
- Single-cycle latency from press to marker move. Back-to-back pulses on consecutive cycles each move the marker.
- Winning edge: at the same edge, led goes to 0, winX goes to 1, and scoreX increments.
- Win display lasts exactly HOLD_CYCLES cycles. On the following edge, led = one-hot CENTER and winX = 0.
- The first press honoured after a hold is one sampled in the first PLAY cycle.
- Final round: at the winning edge, match_over, winX, and the score (== MAX_SCORE) all assert together and then hold.

## Test plan
Sim parameters: NPOS=9, HOLD_CYCLES=4, MAX_SCORE=2.
- Reset, then idle 3 cycles -> led=9'b000010000, scores 0, win1=win2=match_over=0.
- Pulse p1 on 4 separate cycles -> led steps to bit 8. One more p1 pulse -> led=0, win1=1, score1=1. After 4 cycles: led=9'b000010000, win1=0.
- At pos=4, assert p1 and p2 together for 3 cycles -> led unchanged at bit 4. Then p2 alone 5 times -> win2=1, score2=1.
- During a WIN hold, pulse p1 and p2 -> led stays 0, score and counter unaffected, PLAY resumes at CENTER exactly 4 cycles after the win edge.
- Score1=1, then player 1 wins again -> score1=2, match_over=1, win1=1 held for 10+ cycles despite presses. Reset -> all outputs at reset values.
- Assert reset together with p1_press while in PLAY at pos=8 -> no win, led=bit 4, score1 unchanged at 0.
